// File: rtl/hash_check_pkg.sv
// Shared constants, state encoding and byte-order helper for the digest checker.
// Enable HASH_CHECK_BYTE_REVERSE_EN for little-endian (Bitcoin-style) target compare.
package hash_check_pkg;

    localparam int WORD_W    = 10;
    localparam int HASH_W    = 256;
    localparam int NUM_WORDS = 26;
    localparam int PAD_W     = 4;
    localparam int CNT_W     = 16;
    localparam int FRAME_W   = NUM_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMPARE,
        HOLD
    } hc_state_t;

    function automatic logic [255:0] byte_rev256(input logic [255:0] d);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[255-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hash_word_deser.sv
// Serial-to-parallel frame assembler: MSB-first word shift register plus word count.
// frame_done flags the cycle whose shift completes the frame.
module hash_word_deser #(
    parameter int WORD_W    = hash_check_pkg::WORD_W,
    parameter int NUM_WORDS = hash_check_pkg::NUM_WORDS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        shift_en,
    input  logic [WORD_W-1:0]           word_in,
    output logic [NUM_WORDS*WORD_W-1:0] frame,
    output logic                        frame_done
);

    localparam int FRAME_W = NUM_WORDS * WORD_W;
    localparam int CNT_B   = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_B-1:0] LAST = CNT_B'(NUM_WORDS - 1);

    logic [CNT_B-1:0] count;

    assign frame_done = shift_en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (shift_en) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
        end else if (shift_en) begin
            frame <= {frame[FRAME_W-WORD_W-1:0], word_in};
        end
    end

endmodule

// File: rtl/hash_target_check.sv
// Digest stream checker: assembles a frame, compares against the target, hands off the result.
// HASH_CHECK_BYTE_REVERSE_EN selects a byte-reversed (little-endian) digest for the compare.
module hash_target_check #(
    parameter int WORD_W    = hash_check_pkg::WORD_W,
    parameter int HASH_W    = hash_check_pkg::HASH_W,
    parameter int NUM_WORDS = hash_check_pkg::NUM_WORDS,
    parameter int CNT_W     = hash_check_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [WORD_W-1:0] hash_in,
    input  logic [HASH_W-1:0] target_in,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [HASH_W-1:0] digest_out,
    output logic              hit,
    output logic              pad_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  hit_count
);

    import hash_check_pkg::*;

    localparam int FW = NUM_WORDS * WORD_W;
    localparam int PW = FW - HASH_W;

    hc_state_t         state;
    logic [HASH_W-1:0] target_q;
    logic [FW-1:0]     frame;
    logic              frame_done;
    logic              shift_en;
    logic              deser_clr;
    logic              busy;
    logic [HASH_W-1:0] digest_w;
    logic [PW-1:0]     pad_w;
    logic [HASH_W-1:0] cmp_w;

    assign busy      = (state == COMPARE) || (state == HOLD);
    assign shift_en  = valid_in && !busy;
    assign deser_clr = (state == HOLD) && result_ready;
    assign digest_w  = frame[FW-1 -: HASH_W];
    assign pad_w     = frame[PW-1:0];

`ifdef HASH_CHECK_BYTE_REVERSE_EN
    assign cmp_w = byte_rev256(digest_w);
`else
    assign cmp_w = digest_w;
`endif

    hash_word_deser #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_deser (
        .clk        (clk),
        .rst        (rst),
        .clear      (deser_clr),
        .shift_en   (shift_en),
        .word_in    (hash_in),
        .frame      (frame),
        .frame_done (frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target_q     <= '0;
            result_valid <= 1'b0;
            digest_out   <= '0;
            hit          <= 1'b0;
            pad_err      <= 1'b0;
            overrun      <= 1'b0;
            hit_count    <= '0;
        end else begin
            // Words arriving while a result is pending are lost.
            if (valid_in && busy) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        target_q <= target_in;
                        state    <= frame_done ? COMPARE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (frame_done) begin
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    digest_out   <= digest_w;
                    pad_err      <= (pad_w != '0);
                    hit          <= (cmp_w < target_q);
                    result_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (hit && (hit_count != '1)) begin
                            hit_count <= hit_count + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_target_check.sv
// Randomised self-checking bench for hash_target_check against a frame-level model.
// Uses a narrow hit counter so saturation is reachable in a short run.
module tb_hash_target_check;

    localparam int WORD_W    = 10;
    localparam int HASH_W    = 256;
    localparam int NUM_WORDS = 26;
    localparam int CNT_W     = 5;
    localparam int FRAME_W   = NUM_WORDS * WORD_W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam logic [255:0] ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic              clk;
    logic              rst;
    logic              valid_in;
    logic [WORD_W-1:0] hash_in;
    logic [HASH_W-1:0] target_in;
    logic              result_valid;
    logic              result_ready;
    logic [HASH_W-1:0] digest_out;
    logic              hit;
    logic              pad_err;
    logic              overrun;
    logic [CNT_W-1:0]  hit_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    logic exp_ovr  = 1'b0;

    hash_target_check #(
        .WORD_W    (WORD_W),
        .HASH_W    (HASH_W),
        .NUM_WORDS (NUM_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .hash_in      (hash_in),
        .target_in    (target_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .digest_out   (digest_out),
        .hit          (hit),
        .pad_err      (pad_err),
        .overrun      (overrun),
        .hit_count    (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic ref_hit(input logic [255:0] d, input logic [255:0] t);
        logic [255:0] k;
        k = d;
`ifdef HASH_CHECK_BYTE_REVERSE_EN
        k = {<<8{d}};
`endif
        return k < t;
    endfunction

    task automatic send_words(input logic [255:0] d, input logic [3:0] pad,
                              input logic [255:0] t, input int nw,
                              input int gap_at, input int gap_len);
        logic [FRAME_W-1:0] f;
        f = {d, pad};
        for (int i = 0; i < nw; i++) begin
            if (i == gap_at) begin
                valid_in = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            valid_in  = 1'b1;
            hash_in   = f[FRAME_W-1-WORD_W*i -: WORD_W];
            target_in = (i == 0) ? t : rand256();
            @(negedge clk);
        end
        valid_in = 1'b0;
        hash_in  = WORD_W'($urandom);
    endtask

    task automatic run_frame(input string nm, input logic [255:0] d,
                             input logic [3:0] pad, input logic [255:0] t,
                             input int gap_at, input int gap_len);
        logic eh;
        eh = ref_hit(d, t);
        send_words(d, pad, t, NUM_WORDS, gap_at, gap_len);
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early_valid: got %b want 0", nm, result_valid);
        end
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid_latency: got %b want 1", nm, result_valid);
        end
        n_checks++;
        if (digest_out !== d) begin
            n_fail++;
            $display("FAIL %s digest: got %h want %h", nm, digest_out, d);
        end
        n_checks++;
        if (hit !== eh) begin
            n_fail++;
            $display("FAIL %s hit: got %b want %b", nm, hit, eh);
        end
        n_checks++;
        if (pad_err !== (pad != 4'd0)) begin
            n_fail++;
            $display("FAIL %s pad_err: got %b want %b", nm, pad_err, pad != 4'd0);
        end
        if (eh && exp_cnt < CNT_MAX) exp_cnt++;
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0 || hit_count !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s accept: valid %b count %0d want valid 0 count %0d",
                     nm, result_valid, hit_count, exp_cnt);
        end
        n_checks++;
        if (overrun !== exp_ovr) begin
            n_fail++;
            $display("FAIL %s overrun: got %b want %b", nm, overrun, exp_ovr);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        valid_in     = 1'b1;
        hash_in      = WORD_W'($urandom);
        target_in    = rand256();
        result_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        n_checks++;
        if ({result_valid, hit, pad_err, overrun} !== 4'b0 ||
            digest_out !== '0 || hit_count !== '0) begin
            n_fail++;
            $display("FAIL reset: valid %b hit %b pad %b ovr %b cnt %0d dig %h want all 0",
                     result_valid, hit, pad_err, overrun, hit_count, digest_out);
        end
    endtask

    task automatic test_hit();
        run_frame("abc_hit", ABC, 4'd0, '1, -1, 0);
    endtask

    task automatic test_equal_miss();
        run_frame("equal", ABC, 4'd0, ABC, -1, 0);
        run_frame("plus1", ABC, 4'd0, ABC + 256'd1, -1, 0);
        run_frame("minus1", ABC, 4'd0, ABC - 256'd1, -1, 0);
    endtask

    task automatic test_gaps_pad();
        run_frame("gap_pad", ABC, 4'b0101, '1, 10, 3);
        run_frame("gap_rand", rand256(), 4'($urandom), rand256(),
                  $urandom_range(1, 25), $urandom_range(1, 4));
    endtask

    task automatic test_random();
        logic [255:0] d;
        logic [255:0] t;
        for (int i = 0; i < 8; i++) begin
            d = rand256();
            unique case (i % 3)
                0: t = rand256();
                1: t = d + 256'($urandom_range(0, 2));
                default: t = d - 256'($urandom_range(0, 2));
            endcase
            run_frame("random", d, 4'($urandom_range(0, 1)), t, -1, 0);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] d;
        logic         eh;
        d  = rand256();
        eh = ref_hit(d, '1);
        result_ready = 1'b0;
        send_words(d, 4'd0, '1, NUM_WORDS, -1, 0);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            valid_in = (c % 8 == 3);
            hash_in  = WORD_W'($urandom);
            @(negedge clk);
            if (valid_in) exp_ovr = 1'b1;
            valid_in = 1'b0;
            n_checks++;
            if (result_valid !== 1'b1 || digest_out !== d || hit !== eh ||
                pad_err !== 1'b0 || hit_count !== CNT_W'(exp_cnt) ||
                overrun !== exp_ovr) begin
                n_fail++;
                $display("FAIL hold_stable c%0d: v %b hit %b pad %b ovr %b cnt %0d dig %h",
                         c, result_valid, hit, pad_err, overrun, hit_count, digest_out);
            end
        end
        result_ready = 1'b1;
        if (eh && exp_cnt < CNT_MAX) exp_cnt++;
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0 || hit_count !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL bp_accept: valid %b count %0d want 0 / %0d",
                     result_valid, hit_count, exp_cnt);
        end
        run_frame("after_bp", rand256(), 4'd0, rand256(), -1, 0);
    endtask

    task automatic test_rst_midframe();
        send_words(rand256(), 4'hF, '1, 12, -1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;
        exp_ovr = 1'b0;
        n_checks++;
        if ({result_valid, hit, pad_err, overrun} !== 4'b0 ||
            digest_out !== '0 || hit_count !== '0) begin
            n_fail++;
            $display("FAIL mid_rst: valid %b hit %b pad %b ovr %b cnt %0d want all 0",
                     result_valid, hit, pad_err, overrun, hit_count);
        end
        run_frame("post_rst", rand256(), 4'd0, rand256(), -1, 0);
    endtask

    task automatic test_saturation();
        while (exp_cnt < CNT_MAX) begin
            run_frame("sat_fill", rand256(), 4'd0, '1, -1, 0);
        end
        repeat (3) run_frame("sat_hold", rand256(), 4'd0, '1, -1, 0);
        n_checks++;
        if (hit_count !== CNT_W'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL saturate: got %0d want %0d", hit_count, CNT_MAX);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_equal_miss();
        test_gaps_pad();
        test_random();
        test_backpressure();
        test_rst_midframe();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
